// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, request-to-send, ACK check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int RTS_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int HW = $clog2((INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES) + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic [1:0]    clk_s_q, clk_s_d, data_s_q, data_s_d;
    logic          clk_prev_q, clk_prev_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          clk_sync, data_sync, fall;

    assign clk_sync  = clk_s_q[1];
    assign data_sync = data_s_q[1];
    assign fall      = clk_prev_q & ~clk_sync;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        to_d       = to_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        par_d      = par_q;
        clk_s_d    = {clk_s_q[0], ps2_clk_in};
        data_s_d   = {data_s_q[0], ps2_data_in};
        clk_prev_d = clk_sync;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the previous frame's done/err pulse is dropped
                if (tx_start && !done_q && !err_q) begin
                    byte_d    = tx_data;
                    par_d     = ~^tx_data;
                    state_d   = INHIBIT;
                    hold_d    = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            INHIBIT: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(INHIBIT_CYCLES - 1)) begin
                    state_d   = RTS;
                    hold_d    = '0;
                    data_oe_d = 1'b1;
                end
            end
            RTS: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(RTS_CYCLES - 1)) begin
                    state_d  = SEND;
                    clk_oe_d = 1'b0;
                    bit_d    = '0;
                    to_d     = '0;
                end
            end
            SEND: begin
                to_d = to_q + 1'b1;
                if (fall) begin
                    bit_d     = bit_q + 1'b1;
                    data_oe_d = bit_q < 4'd8 ? ~byte_q[bit_q[2:0]] : bit_q == 4'd8 ? ~par_q : 1'b0;
                    state_d   = bit_q == 4'd9 ? WAIT_ACK : SEND;
                end
            end
            WAIT_ACK: begin
                to_d = to_q + 1'b1;
                if (fall) begin
                    state_d = data_sync ? IDLE : WAIT_IDLE;
                    err_d   = data_sync;
                    busy_d  = ~data_sync;
                end
            end
            WAIT_IDLE: begin
                to_d = to_q + 1'b1;
                if (clk_sync && data_sync) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Timeout fires at the last count so the counter stops below TIMEOUT_CYCLES
        if ((state_q == SEND || state_q == WAIT_ACK || state_q == WAIT_IDLE) && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            to_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            clk_s_q    <= 2'b11;
            data_s_q   <= 2'b11;
            clk_prev_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            clk_s_q    <= clk_s_d;
            data_s_q   <= data_s_d;
            clk_prev_q <= clk_prev_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-collector PS/2 device model (device clock scaled to 80 clk cycles).
module tb_ps2_host_tx;
    localparam int I = 20;
    localparam int R = 5;
    localparam int T = 2000;
    localparam int H = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    logic        ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    int          checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int          hi, gap, d0, e0, j;
    logic [10:0] seq;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(I), .RTS_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] b, output int clk_hi, output int rts_gap);
        int d_rise;
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        clk_hi   = 0;
        d_rise   = -1;
        while (ps2_clk_oe && clk_hi < I + R + 50) begin
            if (ps2_data_oe && d_rise < 0) d_rise = clk_hi;
            clk_hi++;
            @(negedge clk);
        end
        rts_gap = clk_hi - d_rise;
    endtask

    task automatic dev_frame(input int inject_at, input int abort_at, input bit ack, output logic [10:0] s);
        s    = '0;
        s[0] = ps2_data_oe;
        for (int k = 1; k <= 10; k++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            if (k == inject_at) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
            repeat (H / 2) @(negedge clk);
            s[k] = ps2_data_oe;
            if (k == abort_at) begin
                dev_clk_low = 1'b0;
                return;
            end
            repeat (H / 2) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge clk);
        dev_data_low = ack;
        repeat (H / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_err", 32'(tx_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hF4, hi, gap);
        check("f4_clk_hold", hi, I + R);
        check("f4_rts_gap", gap, R);
        check("f4_busy", 32'(tx_busy), 1);
        dev_frame(0, 0, 1'b1, seq);
        check("f4_seq", 32'(seq), 'h217);
        check("f4_done", done_cnt - d0, 1);
        check("f4_err", err_cnt - e0, 0);
        check("f4_idle", 32'(tx_busy), 0);

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hED, hi, gap);
        dev_frame(0, 0, 1'b0, seq);
        check("ed_seq", 32'(seq), 'h025);
        check("ed_err", err_cnt - e0, 1);
        check("ed_done", done_cnt - d0, 0);
        check("ed_clk_oe", 32'(ps2_clk_oe), 0);
        check("ed_data_oe", 32'(ps2_data_oe), 0);
        check("ed_idle", 32'(tx_busy), 0);

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hA5, hi, gap);
        j = 0;
        while (!tx_err && j < T + 100) begin
            j++;
            @(negedge clk);
        end
        check("to_latency", j, T);
        @(negedge clk);
        check("to_idle", 32'(tx_busy), 0);
        check("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("to_err", err_cnt - e0, 1);
        check("to_done", done_cnt - d0, 0);

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hFF, hi, gap);
        dev_frame(3, 0, 1'b1, seq);
        check("ff_seq", 32'(seq), 'h001);
        check("ff_done", done_cnt - d0, 1);
        check("ff_err", err_cnt - e0, 0);
        repeat (5) @(negedge clk);
        check("ff_no_restart", 32'({tx_busy, ps2_clk_oe}), 0);

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'h00, hi, gap);
        dev_frame(0, 5, 1'b1, seq);
        check("abort_pre_seq", 32'(seq[5:0]), 'h3F);
        rst = 1'b1;
        @(negedge clk);
        check("abort_clk_oe", 32'(ps2_clk_oe), 0);
        check("abort_data_oe", 32'(ps2_data_oe), 0);
        check("abort_busy", 32'(tx_busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_done", done_cnt - d0, 0);
        check("abort_err", err_cnt - e0, 0);
        check("done_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
